reg_skid: RTL

//  Registered valid/ready pipeline stage (2-entry skid buffer) for DW-bit data.

---
 rtl/reg_skid.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_skid.sv
// Two-entry skid buffer between a stallable producer and consumer.
// Every output (data, valid, ready, count) comes straight from a flop.
module reg_skid #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    count
);

  typedef enum logic [2:0] {
    EMPTY = 3'b001,
    BUSY  = 3'b010,
    FULL  = 3'b100
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    count_q, count_d;
  logic          in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops buffered words but leaves the last head value visible.
    if (clear) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Output flops are loaded from the next state so no decode sits after them.
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    count_d     = 2'd0;
    if (state_d == BUSY) count_d = 2'd1;
    if (state_d == FULL) count_d = 2'd2;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule
